// File: rtl/dbg_pkg.sv
// Shared encodings and default sizes for the debug state port (program loader / state dumper).
package dbg_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DM_WORDS = 32;
    localparam int DEF_IM_WORDS = 64;
    localparam int IDX_W        = 7;
    localparam int TAG_W        = 8;
    localparam int TAG_DM       = 7;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_LOAD_IM  = 2'b01,
        OP_DUMP_RF  = 2'b10,
        OP_DUMP_ALL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE, LOAD, DUMP_RF, DUMP_DM, DRAIN
    } state_e;

    function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len,
                                                   input int unsigned max_len);
        if (32'(len) > max_len) return IDX_W'(max_len);
        return len;
    endfunction
endpackage

// File: rtl/dbg_state_port_if.sv
// Command, load-word and dump-stream handshakes between the debug port and its driver.
interface dbg_state_port_if #(parameter int DATA_W = 32);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [6:0]        cmd_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_tag;
    logic              out_last;

    modport master (
        output cmd_valid, cmd_op, cmd_len, ld_valid, ld_data, out_ready,
        input  cmd_ready, ld_ready, out_valid, out_data, out_tag, out_last
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_len, ld_valid, ld_data, out_ready,
        output cmd_ready, ld_ready, out_valid, out_data, out_tag, out_last
    );
endinterface

// File: rtl/dbg_out_stage.sv
// Single-entry valid/ready output register; a load replaces any element leaving this cycle.
module dbg_out_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              last
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            tag   <= in_tag;
            last  <= in_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dbg_state_port.sv
// Debug port beside the CPU: writes instruction words into IM and streams RF (and DM) contents out.
module dbg_state_port
    import dbg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DM_WORDS = DEF_DM_WORDS,
    parameter int IM_WORDS = DEF_IM_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dbg_state_port_if.slave   bus,
    output logic              im_we_o,
    output logic [31:0]       im_addr_o,
    output logic [DATA_W-1:0] im_wdata_o,
    output logic [4:0]        rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [31:0]       dm_raddr_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              cpu_hold_o
);
    state_e             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n, len, len_n;
    logic               all_mode, all_n;
    logic               cmd_ready, ld_ready, cap, cap_last;
    logic [DATA_W-1:0]  cap_data;
    logic [TAG_W-1:0]   cap_tag;
    logic               out_valid, out_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            all_mode <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len      <= len_n;
            all_mode <= all_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        len_n      = len;
        all_n      = all_mode;
        cmd_ready  = 1'b0;
        ld_ready   = 1'b0;
        cap        = 1'b0;
        cap_data   = '0;
        cap_tag    = '0;
        cap_last   = 1'b0;
        rf_raddr_o = '0;
        dm_raddr_o = '0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    idx_n = '0;
                    case (op_e'(bus.cmd_op))
                        OP_LOAD_IM: begin
                            state_n = LOAD;
                            len_n   = clamp_len(bus.cmd_len, IM_WORDS);
                        end
                        OP_DUMP_RF: begin
                            state_n = DUMP_RF;
                            all_n   = 1'b0;
                        end
                        OP_DUMP_ALL: begin
                            state_n = DUMP_RF;
                            all_n   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                // Gated by reset so an abort can never emit a stray IM write.
                ld_ready = (idx < len) && !rst_i;
                if (len == '0) begin
                    state_n = IDLE;
                end else if (bus.ld_valid && ld_ready) begin
                    idx_n = idx + IDX_W'(1);
                    if (idx == len - IDX_W'(1)) state_n = IDLE;
                end
            end
            DUMP_RF: begin
                rf_raddr_o              = idx[4:0];
                cap                     = !out_valid || bus.out_ready;
                cap_data                = rf_rdata_i;
                cap_tag[TAG_DM-1:0]     = idx;
                cap_last                = !all_mode && (idx == IDX_W'(NUM_REGS - 1));
                if (cap) begin
                    if (idx == IDX_W'(NUM_REGS - 1)) begin
                        idx_n   = '0;
                        state_n = all_mode ? DUMP_DM : DRAIN;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DUMP_DM: begin
                dm_raddr_o              = 32'(idx) << 2;
                cap                     = !out_valid || bus.out_ready;
                cap_data                = dm_rdata_i;
                cap_tag[TAG_DM]         = 1'b1;
                cap_tag[TAG_DM-1:0]     = idx;
                cap_last                = (idx == IDX_W'(DM_WORDS - 1));
                if (cap) begin
                    if (idx == IDX_W'(DM_WORDS - 1)) state_n = DRAIN;
                    else idx_n = idx + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (out_valid && bus.out_ready && out_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    dbg_out_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_out (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (cap),
        .in_data (cap_data),
        .in_tag  (cap_tag),
        .in_last (cap_last),
        .ready   (bus.out_ready),
        .valid   (out_valid),
        .data    (bus.out_data),
        .tag     (bus.out_tag),
        .last    (out_last)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.cmd_ready = cmd_ready;
    assign bus.ld_ready  = ld_ready;
    assign im_we_o       = bus.ld_valid && ld_ready;
    assign im_addr_o     = 32'(idx) << 2;
    assign im_wdata_o    = bus.ld_data;
    assign cpu_hold_o    = (state != IDLE);
endmodule

// File: tb/tb_dbg_state_port.sv
// Bench for dbg_state_port: vector table of commands plus hand sequences for load, latency and reset abort.
module tb_dbg_state_port;
    import dbg_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic        last;
    } elem_t;

    typedef struct {
        op_e        op;
        logic [6:0] len;
        bit         tog;
        int         beats;
        int         wr;
        int         hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        im_we, cpu_hold;
    logic [31:0] im_addr, im_wdata, dm_raddr, rf_rdata, dm_rdata;
    logic [4:0]  rf_raddr;

    logic [31:0] rf_mem[32];
    logic [31:0] dm_mem[32];
    logic        rdy_pat[4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] got_data[1024];
    logic [7:0]  got_tag[1024];
    logic        got_last[1024];
    int          got_cyc[1024];
    int          got_n = 0;
    logic [31:0] im_a_arr[256];
    logic [31:0] im_d_arr[256];
    int          im_n = 0;
    int          stall_seen = 0;
    int          stall_viol = 0;
    logic        stall_prev = 1'b0;
    logic [40:0] held = '0;

    elem_t exp_q[$];

    dbg_state_port_if #(.DATA_W(32)) dif ();

    dbg_state_port dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (dif),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .dm_raddr_o (dm_raddr),
        .dm_rdata_i (dm_rdata),
        .cpu_hold_o (cpu_hold)
    );

    assign rf_rdata = rf_mem[rf_raddr];
    assign dm_rdata = dm_mem[5'(dm_raddr >> 2)];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream beats, IM writes and stall stability, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                stall_seen <= stall_seen + 1;
                if ({dif.out_valid, dif.out_data, dif.out_tag, dif.out_last} !== {1'b1, held})
                    stall_viol <= stall_viol + 1;
            end
            if (dif.out_valid && dif.out_ready && got_n < 1024) begin
                got_data[got_n] <= dif.out_data;
                got_tag[got_n]  <= dif.out_tag;
                got_last[got_n] <= dif.out_last;
                got_cyc[got_n]  <= cyc;
                got_n           <= got_n + 1;
            end
            if (im_we && im_n < 256) begin
                im_a_arr[im_n] <= im_addr;
                im_d_arr[im_n] <= im_wdata;
                im_n           <= im_n + 1;
            end
            stall_prev <= dif.out_valid && !dif.out_ready;
            held       <= {dif.out_data, dif.out_tag, dif.out_last};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rf(input bit all);
        for (int i = 0; i < 32; i++)
            exp_q.push_back('{32'(i * 3), 8'(i), (!all && i == 31)});
    endtask

    task automatic push_dm();
        for (int k = 0; k < 32; k++)
            exp_q.push_back('{32'(100 + k), 8'(8'h80 | k), (k == 31)});
    endtask

    task automatic send_cmd(input op_e op, input logic [6:0] len);
        chk("cmd_ready_idle", 64'(dif.cmd_ready), 64'(1));
        dif.cmd_valid = 1'b1;
        dif.cmd_op    = op;
        dif.cmd_len   = len;
        step();
        dif.cmd_valid = 1'b0;
    endtask

    task automatic drain_idle(input bit tog, input int max_words, output int hold, output bit done);
        int k  = 0;
        int wi = 0;
        hold = 0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!cpu_hold) begin
                done = 1'b1;
                break;
            end
            hold++;
            k++;
            dif.out_ready = tog ? rdy_pat[k % 4] : 1'b1;
            dif.ld_valid  = (wi < max_words) && (k % 2 == 1);
            dif.ld_data   = 32'hA000_0000 + 32'(wi);
            if (dif.ld_valid && dif.ld_ready) wi++;
            step();
        end
        dif.ld_valid  = 1'b0;
        dif.out_ready = 1'b0;
        chk("idle_reached", 64'(done), 64'(1));
    endtask

    task automatic cmp_beats(input int g0, input int n, input bit gapchk);
        int    gaps = 0;
        elem_t e;
        chk("beat_count", 64'(got_n - g0), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (g0 + i < got_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("beat%0d", i), {23'b0, got_data[g0+i], got_tag[g0+i], got_last[g0+i]},
                    {23'b0, e.data, e.tag, e.last});
                if (gapchk && i > 0 && got_cyc[g0+i] != got_cyc[g0+i-1] + 1) gaps++;
            end
        end
        if (gapchk) chk("no_bubble", 64'(gaps), 64'(0));
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int g0 = got_n;
        int i0 = im_n;
        int s0 = stall_seen;
        int v0 = stall_viol;
        int hold;
        bit done;
        if (v.op == OP_DUMP_RF) push_rf(1'b0);
        if (v.op == OP_DUMP_ALL) begin
            push_rf(1'b1);
            push_dm();
        end
        dif.out_ready = v.tog ? rdy_pat[0] : 1'b1;
        send_cmd(v.op, v.len);
        drain_idle(v.tog, 70, hold, done);
        cmp_beats(g0, v.beats, !v.tog);
        if (v.hold >= 0) chk("hold_cycles", 64'(hold), 64'(v.hold));
        chk("im_writes", 64'(im_n - i0), 64'(v.wr));
        for (int i = 0; i < v.wr && i0 + i < im_n; i++)
            chk($sformatf("im_wr%0d", i), {im_a_arr[i0+i], im_d_arr[i0+i]},
                {32'(4 * i), 32'hA000_0000 + 32'(i)});
        if (v.tog) begin
            chk("stall_stable", 64'(stall_viol - v0), 64'(0));
            chk("stalls_seen", 64'(stall_seen > s0), 64'(1));
        end
    endtask

    vec_t        tbl[7];
    logic [31:0] words[3];

    initial begin
        int  g0, i0, hold;
        bit  done;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'(i * 3);
            dm_mem[i] = 32'(100 + i);
        end
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        words[0] = 32'h1111_AAAA; words[1] = 32'h2222_BBBB; words[2] = 32'h3333_CCCC;
        tbl[0] = '{OP_NOP,      7'd0,  1'b0, 0,  0,  0};
        tbl[1] = '{OP_LOAD_IM,  7'd0,  1'b0, 0,  0,  1};
        tbl[2] = '{OP_DUMP_RF,  7'd0,  1'b0, 32, 0,  33};
        tbl[3] = '{OP_DUMP_ALL, 7'd0,  1'b0, 64, 0,  65};
        tbl[4] = '{OP_DUMP_RF,  7'd0,  1'b1, 32, 0,  -1};
        tbl[5] = '{OP_LOAD_IM,  7'd5,  1'b0, 0,  5,  -1};
        tbl[6] = '{OP_LOAD_IM,  7'd70, 1'b0, 0,  64, -1};

        dif.cmd_valid = 1'b0; dif.cmd_op = '0; dif.cmd_len = '0;
        dif.ld_valid = 1'b0; dif.ld_data = '0; dif.out_ready = 1'b0;
        step(); step();
        chk("rst_cmd_ready", 64'(dif.cmd_ready), 64'(1));
        chk("rst_ld_ready", 64'(dif.ld_ready), 64'(0));
        chk("rst_hold", 64'(cpu_hold), 64'(0));
        chk("rst_out", {22'b0, dif.out_valid, dif.out_data, dif.out_tag, dif.out_last}, 64'(0));
        chk("rst_addrs", {27'b0, im_we, rf_raddr, dm_raddr}, 64'(0));
        rst = 1'b0;
        step();

        // Load three words with idle gaps between them.
        i0 = im_n;
        send_cmd(OP_LOAD_IM, 7'd3);
        chk("load_hold", 64'(cpu_hold), 64'(1));
        for (int w = 0; w < 3; w++) begin
            dif.ld_valid = 1'b0;
            #1;
            chk("gap_no_we", 64'(im_we), 64'(0));
            step();
            dif.ld_valid = 1'b1;
            dif.ld_data  = words[w];
            #1;
            chk($sformatf("we%0d", w), {31'b0, im_we, im_addr}, {31'b0, 1'b1, 32'(4 * w)});
            chk($sformatf("wdata%0d", w), 64'(im_wdata), 64'(words[w]));
            step();
            if (w < 2) chk("cmd_ready_busy", 64'(dif.cmd_ready), 64'(0));
        end
        dif.ld_valid = 1'b0;
        #1;
        chk("load_done_ready", {62'b0, dif.cmd_ready, cpu_hold}, 64'b10);
        chk("load_write_count", 64'(im_n - i0), 64'(3));

        // First element latency with the consumer stalled, then drain.
        g0 = got_n;
        push_rf(1'b0);
        send_cmd(OP_DUMP_RF, 7'd0);
        chk("lat_valid_t1", 64'(dif.out_valid), 64'(0));
        step();
        chk("lat_valid_t2", 64'(dif.out_valid), 64'(1));
        chk("lat_first", {24'b0, dif.out_data, dif.out_tag}, 64'(0));
        chk("rf_raddr_stalled", 64'(rf_raddr), 64'(1));
        step(); step();
        chk("stall_first", {23'b0, dif.out_valid, dif.out_data, dif.out_tag, dif.out_last},
            {23'b0, 1'b1, 32'd0, 8'd0, 1'b0});
        drain_idle(1'b0, 0, hold, done);
        cmp_beats(g0, 32, 1'b0);
        chk("dm_raddr_idle", 64'(dm_raddr), 64'(0));

        // Reset in the middle of a dump.
        g0 = got_n;
        i0 = im_n;
        push_rf(1'b0);
        dif.out_ready = 1'b1;
        send_cmd(OP_DUMP_RF, 7'd0);
        for (int c = 0; c < 50 && got_n - g0 < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dif.out_ready = 1'b0;
        chk("abort_state", {61'b0, dif.out_valid, cpu_hold, dif.cmd_ready}, 64'b001);
        cmp_beats(g0, 5, 1'b1);
        chk("abort_no_im", 64'(im_n - i0), 64'(0));
        step();
        run_vec(tbl[2]);

        for (int t = 0; t < 7; t++) begin
            run_vec(tbl[t]);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
